// File: rtl/rv_plic_target_pkg.sv
// Shared types and helpers for the PLIC target controller and its priority arbiter.
package rv_plic_target_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COOL0 = 2'd1,
    COOL1 = 2'd2
  } state_e;

  // Upper bounds for the generic priority extraction helper.
  localparam int unsigned MaxPrioBits = 4096;
  localparam int unsigned MaxPrioW    = 16;

  function automatic logic [MaxPrioW-1:0] prio_of(
    input logic [MaxPrioBits-1:0] prioVec,
    input int unsigned            id,
    input int unsigned            prioW
  );
    logic [MaxPrioBits-1:0] shifted;
    logic [MaxPrioW-1:0]    mask;
    shifted = prioVec >> (id * prioW);
    mask    = MaxPrioW'((32'd1 << prioW) - 32'd1);
    return shifted[MaxPrioW-1:0] & mask;
  endfunction

endpackage

// File: rtl/rv_plic_prio_arbiter.sv
// Combinational max-priority tree over eligible sources; ties resolve to the lower ID.
module rv_plic_prio_arbiter #(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned PRIO_W   = 3,
  parameter int unsigned ID_W     = $clog2(N_SOURCE)
) (
  input  logic [N_SOURCE-1:0]        elig_i,
  input  logic [N_SOURCE*PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]            id_o,
  output logic [PRIO_W-1:0]          prio_o
);

  localparam int unsigned Levels = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;
  localparam int unsigned Leaves = 1 << Levels;
  localparam int unsigned Nodes  = 2 * Leaves - 1;

  logic              nodeVld  [Nodes];
  logic [PRIO_W-1:0] nodePrio [Nodes];
  logic [ID_W-1:0]   nodeId   [Nodes];

  // Heap-ordered tree: node n has children 2n+1 (lower IDs) and 2n+2, so >= keeps the lower ID.
  always_comb begin
    for (int n = 0; n < Nodes; n++) begin
      nodeVld[n]  = 1'b0;
      nodePrio[n] = '0;
      nodeId[n]   = '0;
    end
    for (int i = 0; i < Leaves; i++) begin
      if (i < N_SOURCE) begin
        nodeVld[Leaves-1+i]  = elig_i[i];
        nodePrio[Leaves-1+i] = prio_i[i*PRIO_W +: PRIO_W];
        nodeId[Leaves-1+i]   = ID_W'(i);
      end
    end
    for (int n = Leaves - 2; n >= 0; n--) begin
      if (nodeVld[2*n+1] && (!nodeVld[2*n+2] || (nodePrio[2*n+1] >= nodePrio[2*n+2]))) begin
        nodeVld[n]  = nodeVld[2*n+1];
        nodePrio[n] = nodePrio[2*n+1];
        nodeId[n]   = nodeId[2*n+1];
      end else begin
        nodeVld[n]  = nodeVld[2*n+2];
        nodePrio[n] = nodePrio[2*n+2];
        nodeId[n]   = nodeId[2*n+2];
      end
    end
  end

  assign id_o   = nodeVld[0] ? nodeId[0]   : '0;
  assign prio_o = nodeVld[0] ? nodePrio[0] : '0;

endmodule

// File: rtl/rv_plic_target_ctrl.sv
// Per-target PLIC controller: picks the best pending source, raises irq, and turns claim reads
// and complete writes into one-cycle pulses for the gateways while tracking in-service sources.
module rv_plic_target_ctrl
  import rv_plic_target_pkg::*;
#(
  parameter int unsigned N_SOURCE = 32,
  parameter int unsigned PRIO_W   = 3,
  parameter int unsigned ID_W     = $clog2(N_SOURCE)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SOURCE-1:0]        ip,
  input  logic [N_SOURCE-1:0]        ie,
  input  logic [N_SOURCE*PRIO_W-1:0] prio,
  input  logic [PRIO_W-1:0]          threshold,
  input  logic                       claim_req_i,
  output logic                       claim_rdy_o,
  output logic                       claim_vld_o,
  output logic [ID_W-1:0]            claim_id_o,
  input  logic                       complete_req_i,
  input  logic [ID_W-1:0]            complete_id_i,
  output logic                       complete_err_o,
  output logic [N_SOURCE-1:0]        claim,
  output logic [N_SOURCE-1:0]        complete,
  output logic                       irq_o,
  output logic [ID_W-1:0]            irq_id_o
);

  state_e              state_q, state_d;
  logic [N_SOURCE-1:0] elig;
  logic [ID_W-1:0]     arbId;
  logic [PRIO_W-1:0]   arbPrio;
  logic [ID_W-1:0]     bestId_q;
  logic [PRIO_W-1:0]   bestPrio_q;
  logic [N_SOURCE-1:0] inService_q, inService_d;
  logic                claimVld_q, claimVld_d;
  logic [ID_W-1:0]     claimId_q, claimId_d;
  logic [N_SOURCE-1:0] claim_q, claim_d;
  logic [N_SOURCE-1:0] complete_q, complete_d;
  logic                completeErr_q, completeErr_d;
  logic                bestValid;
  logic                claimAccept;
  logic                completeOk;

  always_comb begin
    elig = '0;
    for (int unsigned i = 1; i < N_SOURCE; i++) begin
      elig[i] = ip[i] & ie[i] &
                (PRIO_W'(prio_of(MaxPrioBits'(prio), i, PRIO_W)) > threshold);
    end
  end

  rv_plic_prio_arbiter #(
    .N_SOURCE (N_SOURCE),
    .PRIO_W   (PRIO_W),
    .ID_W     (ID_W)
  ) u_arbiter (
    .elig_i (elig),
    .prio_i (prio),
    .id_o   (arbId),
    .prio_o (arbPrio)
  );

  // A registered winner always carries a priority above threshold, hence nonzero.
  assign bestValid   = (bestId_q != '0) && (bestPrio_q != '0);
  assign claimAccept = claim_req_i && (state_q == IDLE);
  assign completeOk  = complete_req_i && (complete_id_i != '0) &&
                       ({1'b0, complete_id_i} < (ID_W+1)'(N_SOURCE)) &&
                       inService_q[complete_id_i];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (claimAccept && (bestId_q != '0)) state_d = COOL0;
      COOL0:   state_d = COOL1;
      COOL1:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Complete is applied before claim so a same-cycle claim of the completed ID leaves it in service.
  always_comb begin
    inService_d   = inService_q;
    claimVld_d    = 1'b0;
    claimId_d     = '0;
    claim_d       = '0;
    complete_d    = '0;
    completeErr_d = 1'b0;
    if (completeOk) begin
      complete_d[complete_id_i]  = 1'b1;
      inService_d[complete_id_i] = 1'b0;
    end else if (complete_req_i) begin
      completeErr_d = 1'b1;
    end
    if (claimAccept) begin
      claimVld_d = 1'b1;
      claimId_d  = bestId_q;
      if (bestId_q != '0) begin
        claim_d[bestId_q]     = 1'b1;
        inService_d[bestId_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      bestId_q      <= '0;
      bestPrio_q    <= '0;
      inService_q   <= '0;
      claimVld_q    <= 1'b0;
      claimId_q     <= '0;
      claim_q       <= '0;
      complete_q    <= '0;
      completeErr_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bestId_q      <= arbId;
      bestPrio_q    <= arbPrio;
      inService_q   <= inService_d;
      claimVld_q    <= claimVld_d;
      claimId_q     <= claimId_d;
      claim_q       <= claim_d;
      complete_q    <= complete_d;
      completeErr_q <= completeErr_d;
    end
  end

  assign claim_rdy_o    = (state_q == IDLE) && !rst_i;
  assign claim_vld_o    = claimVld_q;
  assign claim_id_o     = claimId_q;
  assign claim          = claim_q;
  assign complete       = complete_q;
  assign complete_err_o = completeErr_q;
  assign irq_o          = bestValid && (state_q == IDLE);
  assign irq_id_o       = irq_o ? bestId_q : '0;

endmodule

// File: tb/tb_rv_plic_target_ctrl.sv
// Randomized scoreboard bench for rv_plic_target_ctrl with a behavioural PLIC target model.
module tb_rv_plic_target_ctrl;

  localparam int NS = 32;
  localparam int PW = 3;
  localparam int IW = 5;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NS-1:0]   ip;
  logic [NS-1:0]   ie;
  logic [NS*PW-1:0] prio;
  logic [PW-1:0]   threshold;
  logic            claim_req_i;
  logic            claim_rdy_o;
  logic            claim_vld_o;
  logic [IW-1:0]   claim_id_o;
  logic            complete_req_i;
  logic [IW-1:0]   complete_id_i;
  logic            complete_err_o;
  logic [NS-1:0]   claim;
  logic [NS-1:0]   complete;
  logic            irq_o;
  logic [IW-1:0]   irq_id_o;

  int checks = 0;
  int errors = 0;

  // Expected responses: claim IDs, and complete IDs (0 means the complete must be rejected).
  int claimQ[$];
  int cplQ[$];
  bit inSvc[NS];
  int modelBest;
  int modelCool;

  always #5 clk_i = ~clk_i;

  rv_plic_target_ctrl #(
    .N_SOURCE (NS),
    .PRIO_W   (PW),
    .ID_W     (IW)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ip             (ip),
    .ie             (ie),
    .prio           (prio),
    .threshold      (threshold),
    .claim_req_i    (claim_req_i),
    .claim_rdy_o    (claim_rdy_o),
    .claim_vld_o    (claim_vld_o),
    .claim_id_o     (claim_id_o),
    .complete_req_i (complete_req_i),
    .complete_id_i  (complete_id_i),
    .complete_err_o (complete_err_o),
    .claim          (claim),
    .complete       (complete),
    .irq_o          (irq_o),
    .irq_id_o       (irq_id_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NS-1:0] bitOf(input int id);
    logic [NS-1:0] v;
    v = '0;
    if (id != 0) v[id] = 1'b1;
    return v;
  endfunction

  // Highest priority above threshold among pending, enabled sources 1..NS-1; first found wins ties.
  function automatic int refBest();
    int best;
    int bestP;
    int p;
    best  = 0;
    bestP = 0;
    for (int i = 1; i < NS; i++) begin
      p = int'(prio[i*PW +: PW]);
      if (ip[i] && ie[i] && (p > int'(threshold)) && (p > bestP)) begin
        best  = i;
        bestP = p;
      end
    end
    return best;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NS; i++) inSvc[i] = 1'b0;
    modelBest = 0;
    modelCool = 0;
    claimQ.delete();
    cplQ.delete();
  endtask

  task automatic modelEdge();
    bit claimTake;
    int cid;
    int newBest;
    if (rst_i) begin
      modelReset();
      return;
    end
    claimTake = claim_req_i && (modelCool == 0);
    cid       = int'(complete_id_i);
    newBest   = refBest();
    if (complete_req_i) begin
      if ((cid != 0) && (cid < NS) && inSvc[cid]) begin
        inSvc[cid] = 1'b0;
        cplQ.push_back(cid);
      end else begin
        cplQ.push_back(0);
      end
    end
    if (claimTake) begin
      claimQ.push_back(modelBest);
      if (modelBest != 0) inSvc[modelBest] = 1'b1;
    end
    if (claimTake && (modelBest != 0)) modelCool = 2;
    else if (modelCool > 0) modelCool--;
    modelBest = newBest;
  endtask

  // One clock: model follows the edge, strobes drop, and the gateway keeps in-service ip low.
  task automatic applyStimulus();
    @(posedge clk_i);
    modelEdge();
    #1;
    claim_req_i    = 1'b0;
    complete_req_i = 1'b0;
    for (int i = 0; i < NS; i++) if (inSvc[i]) ip[i] = 1'b0;
  endtask

  task automatic setPrio(input int id, input int p);
    prio[id*PW +: PW] = PW'(p);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " irq_o"}, 64'(irq_o), 64'd0);
    checkOutput({tag, " irq_id_o"}, 64'(irq_id_o), 64'd0);
    checkOutput({tag, " claim_rdy_o"}, 64'(claim_rdy_o), 64'd0);
    checkOutput({tag, " claim_vld_o"}, 64'(claim_vld_o), 64'd0);
    checkOutput({tag, " claim_id_o"}, 64'(claim_id_o), 64'd0);
    checkOutput({tag, " claim"}, 64'(claim), 64'd0);
    checkOutput({tag, " complete"}, 64'(complete), 64'd0);
    checkOutput({tag, " complete_err_o"}, 64'(complete_err_o), 64'd0);
  endtask

  // Monitor: mid-cycle compare of every output against the model and the scoreboard queues.
  initial begin : monitor
    int e;
    bit expIrq;
    forever begin
      @(negedge clk_i);
      expIrq = (modelBest != 0) && (modelCool == 0);
      checkOutput("irq_o", 64'(irq_o), 64'(expIrq));
      checkOutput("irq_id_o", 64'(irq_id_o), expIrq ? 64'(modelBest) : 64'd0);
      checkOutput("claim_rdy_o", 64'(claim_rdy_o), 64'((modelCool == 0) && !rst_i));
      if (claimQ.size() > 0) begin
        e = claimQ.pop_front();
        checkOutput("claim_vld_o", 64'(claim_vld_o), 64'd1);
        checkOutput("claim_id_o", 64'(claim_id_o), 64'(e));
        checkOutput("claim pulse", 64'(claim), 64'(bitOf(e)));
      end else begin
        checkOutput("claim_vld_o idle", 64'(claim_vld_o), 64'd0);
        checkOutput("claim idle", 64'(claim), 64'd0);
      end
      if (cplQ.size() > 0) begin
        e = cplQ.pop_front();
        checkOutput("complete_err_o", 64'(complete_err_o), (e == 0) ? 64'd1 : 64'd0);
        checkOutput("complete pulse", 64'(complete), 64'(bitOf(e)));
      end else begin
        checkOutput("complete_err_o idle", 64'(complete_err_o), 64'd0);
        checkOutput("complete idle", 64'(complete), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int svc[$];
    rst_i          = 1'b1;
    ip             = '1;
    ie             = '1;
    prio           = '1;
    threshold      = '0;
    claim_req_i    = 1'b0;
    complete_req_i = 1'b0;
    complete_id_i  = '0;
    modelReset();

    // Reset with everything pending, then irq rises one edge after release.
    #1;
    checkResetOutputs("reset async");
    applyStimulus();
    applyStimulus();
    checkResetOutputs("reset held");
    rst_i = 1'b0;
    checkOutput("irq before first edge", 64'(irq_o), 64'd0);
    applyStimulus();
    checkOutput("irq after release", 64'(irq_o), 64'd1);
    checkOutput("irq_id after release", 64'(irq_id_o), 64'd1);

    // Arbitration and tie-break.
    ip = '0; prio = '0; threshold = 3'd1;
    setPrio(3, 2); setPrio(5, 6);
    ip[3] = 1'b1; ip[5] = 1'b1;
    applyStimulus();
    checkOutput("arb highest prio", 64'(irq_id_o), 64'd5);
    setPrio(5, 2);
    applyStimulus();
    checkOutput("arb tie lowest id", 64'(irq_id_o), 64'd3);

    // Threshold boundary.
    ip = '0; prio = '0; ip[7] = 1'b1; setPrio(7, 4); threshold = 3'd4;
    applyStimulus();
    checkOutput("prio equal thr", 64'(irq_o), 64'd0);
    threshold = 3'd3;
    applyStimulus();
    checkOutput("prio above thr", 64'(irq_o), 64'd1);
    checkOutput("prio above thr id", 64'(irq_id_o), 64'd7);

    // Claim and cooldown.
    ip = '0; prio = '0; ip[5] = 1'b1; setPrio(5, 6); threshold = 3'd1;
    applyStimulus();
    claim_req_i = 1'b1;
    applyStimulus();
    checkOutput("claim vld", 64'(claim_vld_o), 64'd1);
    checkOutput("claim id 5", 64'(claim_id_o), 64'd5);
    checkOutput("claim vec 5", 64'(claim), 64'h20);
    checkOutput("rdy low cool0", 64'(claim_rdy_o), 64'd0);
    applyStimulus();
    checkOutput("claim one cycle", 64'(claim), 64'd0);
    checkOutput("rdy low cool1", 64'(claim_rdy_o), 64'd0);
    applyStimulus();
    checkOutput("rdy back", 64'(claim_rdy_o), 64'd1);
    claim_req_i = 1'b1;
    applyStimulus();
    checkOutput("empty claim vld", 64'(claim_vld_o), 64'd1);
    checkOutput("empty claim id", 64'(claim_id_o), 64'd0);
    checkOutput("empty claim vec", 64'(claim), 64'd0);

    // Complete: good, repeated, id 0, not in service.
    complete_req_i = 1'b1; complete_id_i = 5'd5;
    applyStimulus();
    checkOutput("complete 5", 64'(complete), 64'h20);
    checkOutput("complete 5 err", 64'(complete_err_o), 64'd0);
    complete_req_i = 1'b1; complete_id_i = 5'd5;
    applyStimulus();
    checkOutput("repeat complete err", 64'(complete_err_o), 64'd1);
    checkOutput("repeat complete vec", 64'(complete), 64'd0);
    complete_req_i = 1'b1; complete_id_i = 5'd0;
    applyStimulus();
    checkOutput("complete id0 err", 64'(complete_err_o), 64'd1);
    complete_req_i = 1'b1; complete_id_i = 5'd31;
    applyStimulus();
    checkOutput("complete id31 err", 64'(complete_err_o), 64'd1);

    // Simultaneous claim of 9 and complete of 5.
    ip[5] = 1'b1;
    applyStimulus();
    claim_req_i = 1'b1;
    applyStimulus();
    checkOutput("claim 5 again", 64'(claim), 64'h20);
    ip[9] = 1'b1; setPrio(9, 5);
    applyStimulus();
    applyStimulus();
    checkOutput("best 9 ready", 64'(irq_id_o), 64'd9);
    claim_req_i = 1'b1; complete_req_i = 1'b1; complete_id_i = 5'd5;
    applyStimulus();
    checkOutput("conc claim 9", 64'(claim), 64'h200);
    checkOutput("conc complete 5", 64'(complete), 64'h20);
    complete_req_i = 1'b1; complete_id_i = 5'd9;
    applyStimulus();
    checkOutput("in service 9", 64'(complete), 64'h200);
    complete_req_i = 1'b1; complete_id_i = 5'd5;
    applyStimulus();
    checkOutput("5 not in service", 64'(complete_err_o), 64'd1);

    // Random traffic, including one reset mid-sequence.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 3) == 0) ip = $urandom;
      for (int i = 0; i < NS; i++) if (inSvc[i]) ip[i] = 1'b0;
      if ($urandom_range(0, 15) == 0) ie = $urandom | $urandom;
      if ($urandom_range(0, 15) == 0) prio = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 31) == 0) threshold = PW'($urandom_range(0, 4));
      claim_req_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        svc.delete();
        for (int i = 0; i < NS; i++) if (inSvc[i]) svc.push_back(i);
        complete_req_i = 1'b1;
        if ((svc.size() > 0) && ($urandom_range(0, 3) != 0))
          complete_id_i = IW'(svc[$urandom_range(0, svc.size() - 1)]);
        else
          complete_id_i = IW'($urandom_range(0, NS - 1));
      end
      if (cyc == 700) begin
        rst_i = 1'b1;
        modelReset();
        #1;
        checkResetOutputs("reset mid-run");
        applyStimulus();
        rst_i = 1'b0;
      end else begin
        applyStimulus();
      end
    end

    applyStimulus();
    applyStimulus();
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
